pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in; ignored when sub=1.
REQ-010 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result modulo 2^WIDTH.
REQ-014 SHALL have port carry_out  output  1  carry from MSB; for sub, 1 = no borrow.
REQ-015 SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL split the add into STAGES slices of WIDTH/STAGES bits; stage k SHALL add slice k, LSB slice first, using the carry registered by stage k-1.
REQ-017 Each stage SHALL register the remaining unprocessed operand slices, already-computed sum slices, inter-slice carry, the A/B MSBs (post-inversion) and a valid bit.
REQ-018 Latency SHALL be exactly STAGES cycles from accepted input to out_valid with no back-pressure.
REQ-019 Transfer rule: an input is accepted when in_valid && in_ready; an output is consumed when out_valid && out_ready.
REQ-020 The pipeline SHALL advance (all stages shift) when advance = out_ready || !out_valid; otherwise every stage SHALL hold.
REQ-021 in_ready SHALL equal advance (combinational from out_ready and out_valid only, not from in_valid).
REQ-022 On advance with no accepted input, stage 0 SHALL load a bubble (valid=0).
REQ-023 Throughput SHALL be one result per cycle under continuous in_valid and out_ready.
REQ-024 sum/carry_out/overflow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 overflow SHALL be (A_msb == B'_msb) && (sum_msb != A_msb), where B' is B after inversion for sub.
REQ-026 Results SHALL be delivered in acceptance order; none dropped or duplicated under any back-pressure pattern.
REQ-027 STAGES=1 SHALL degenerate to a single registered WIDTH-bit adder, latency 1.

Reset
REQ-028 rst_n low SHALL asynchronously clear all stage valid bits; out_valid=0, sum=0, carry_out=0, overflow=0 while in reset.
REQ-029 After rst_n deassertion in_ready SHALL be 1 in the first cycle; in-flight data at reset time SHALL be discarded.

Structure
REQ-030 Package pipe_adder_pkg SHALL hold the default WIDTH/STAGES constants and the op encoding (OP_ADD=0, OP_SUB=1).
REQ-031 One sub-module adder_slice (SLICE_W-bit a, b, cin -> sum, cout, combinational) SHALL be instantiated once per stage.

Verification
REQ-032 Reset, then a=0, b=1, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles later, sum=1, carry_out=0, overflow=0.
REQ-033 a=32'hFFFFFFFF, b=1 -> sum=0, carry_out=1, overflow=0 (full carry ripple across all 4 stages).
REQ-034 a=32'h7FFFFFFF, b=1 -> sum=32'h80000000, overflow=1; sub with a=5, b=7 -> sum=32'hFFFFFFFE, carry_out=0.
REQ-035 Stream (25,49),(650,1000),(7000,15000),(6758,2112) back-to-back, out_ready toggling 1/0 each cycle -> outputs 74,1650,22000,8870 in order, each held while out_ready=0, in_ready tracking advance.
REQ-036 Fill pipeline with 4 ops, hold out_ready=0 for 10 cycles -> in_ready=0, out_valid stays 1, sum stable; then assert rst_n=0 mid-stall -> out_valid=0 immediately; after release no stale result emerges.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
// Shared constants and types for the pipelined adder:
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   op_e                   : operation select encoding (add / subtract)
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// Purely combinational SLICE_W-bit ripple adder used by every pipeline stage.
// Ports:
//   a, b  : slice operands
//   cin   : carry into the slice LSB
//   sum   : slice result
//   cout  : carry out of the slice MSB
// -----------------------------------------------------------------------------
module adder_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// Pipelined WIDTH-bit adder/subtractor split into STAGES equal slices. Stage k
// adds slice k (LSB slice first) using the carry registered by stage k-1, so a
// result appears STAGES cycles after acceptance. Valid/ready handshake on both
// sides; the whole pipeline stalls when the output is held.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready depends only on output side)
//   a, b, cin, sub       : operands; sub=1 computes a - b and ignores cin
//   out_valid / out_ready: output handshake
//   sum, carry_out       : result mod 2^WIDTH, MSB carry (sub: 1 = no borrow)
//   overflow             : two's-complement signed overflow
// WIDTH must be an integer multiple of STAGES.
// -----------------------------------------------------------------------------
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SLICE_W = WIDTH / STAGES;

    // Per-stage registers: full operand vectors (post-inversion B) so that the
    // unprocessed slices and the MSBs travel with the partial sum.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    // Inputs seen by each stage: stage 0 from the ports, stage k from stage k-1.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];

    logic [SLICE_W-1:0] slc_s [STAGES];
    logic [STAGES-1:0]  slc_c;
    logic [WIDTH-1:0]   nxt_s [STAGES];

    logic advance;
    op_e  op;

    assign op       = op_e'(sub);
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned and no latch is inferred.
        src_v    = '0;
        src_c    = '0;
        src_v[0] = in_valid;
        // Subtraction is A + ~B + 1: the +1 rides in as the stage-0 carry.
        src_c[0] = (op == OP_SUB) ? 1'b1 : cin;
        src_a[0] = a;
        src_b[0] = (op == OP_SUB) ? ~b : b;
        src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_c[k] = c_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_slice #(.SLICE_W(SLICE_W)) u_slice (
            .a    (src_a[k][k*SLICE_W +: SLICE_W]),
            .b    (src_b[k][k*SLICE_W +: SLICE_W]),
            .cin  (src_c[k]),
            .sum  (slc_s[k]),
            .cout (slc_c[k])
        );
    end

    // Merge each stage's freshly computed slice into the partial sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_s[k] = src_s[k];
            nxt_s[k][k*SLICE_W +: SLICE_W] = slc_s[k];
        end
    end

    // NOTE: data registers are reset along with the valid bits because the
    // outputs are driven straight from the last stage and must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            // NOTE: non-blocking assignments so every stage samples its
            // predecessor's pre-edge value and the pipeline shifts as one.
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= src_v[k];
                c_q[k] <= slc_c[k];
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                s_q[k] <= nxt_s[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry_out = c_q[STAGES-1];
    // Same-sign operands producing an opposite-sign result.
    assign overflow  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                       (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

    // Operand bits below the MSB are dead once they leave the final stage.
    logic unused_ok;
    assign unused_ok = ^{a_q[STAGES-1][WIDTH-2:0], b_q[STAGES-1][WIDTH-2:0]};

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
// Self-checking bench for pipe_adder (WIDTH=32, STAGES=4). A monitor on the
// falling edge keeps an arithmetic reference queue of accepted operations,
// checks every consumed result, output stability under back-pressure, the
// in_ready rule and reset behaviour. Directed sequences pin literal results.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         ov;
        int           acyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         ov;
        int           lat;
    } got_t;

    exp_t exp_q [$];
    got_t got_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic         hold_pend = 1'b0;
    logic [W-1:0] h_sum;
    logic         h_c;
    logic         h_ov;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic ci, input logic si);
        exp_t   e;
        longint sa, sb, t;
        sa = longint'($signed(ai));
        sb = longint'($signed(bi));
        if (si) begin
            t    = sa - sb;
            e.c  = (ai >= bi);
        end else begin
            t    = sa + sb + longint'(ci);
            e.c  = ((64'(ai) + 64'(bi) + 64'(ci)) >> W) != 0;
        end
        e.s    = t[W-1:0];
        e.ov   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        e.acyc = 0;
        return e;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_sum", 64'(sum), 64'd0);
            check("reset_carry", 64'(carry_out), 64'd0);
            check("reset_overflow", 64'(overflow), 64'd0);
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(out_ready || !out_valid));
            if (hold_pend) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_sum", 64'(sum), 64'(h_sum));
                check("hold_carry", 64'(carry_out), 64'(h_c));
                check("hold_overflow", 64'(overflow), 64'(h_ov));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_output: got sum %0h with nothing outstanding", sum);
                end else begin
                    exp_t e;
                    got_t g;
                    e = exp_q.pop_front();
                    check("result_sum", 64'(sum), 64'(e.s));
                    check("result_carry", 64'(carry_out), 64'(e.c));
                    check("result_overflow", 64'(overflow), 64'(e.ov));
                    g.s = sum; g.c = carry_out; g.ov = overflow; g.lat = cyc - e.acyc;
                    got_q.push_back(g);
                end
            end
            hold_pend = out_valid && !out_ready;
            h_sum = sum; h_c = carry_out; h_ov = overflow;
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(a, b, cin, sub);
                e.acyc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_results(input int want, input string nm);
        int t;
        t = 0;
        while (got_q.size() < want && t < 60) begin
            tick();
            t++;
        end
        if (got_q.size() < want) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d results expected %0d", nm, got_q.size(), want);
        end
    endtask

    task automatic send_one(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                            input logic si, input logic [W-1:0] es, input logic ec,
                            input logic eov, input string nm);
        int n0;
        n0 = got_q.size();
        out_ready = 1'b1;
        in_valid = 1'b1; a = ai; b = bi; cin = ci; sub = si;
        tick();
        in_valid = 1'b0;
        wait_results(n0 + 1, nm);
        if (got_q.size() > n0) begin
            check({nm, "_sum"}, 64'(got_q[n0].s), 64'(es));
            check({nm, "_carry"}, 64'(got_q[n0].c), 64'(ec));
            check({nm, "_overflow"}, 64'(got_q[n0].ov), 64'(eov));
            check({nm, "_latency"}, 64'(got_q[n0].lat), 64'(S));
        end
    endtask

    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] ve [4];

    initial begin
        int n0, i, k, vcnt;
        bit tog;

        // Reset and release.
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        check("out_valid_after_reset", 64'(out_valid), 64'd0);

        // Basic and boundary operations.
        send_one(32'd0, 32'd1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0, "add_0_1");
        send_one(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, "full_ripple");
        send_one(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "pos_overflow");
        send_one(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_borrow");
        send_one(32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0, "sub_ignores_cin");
        send_one(32'd10, 32'd20, 1'b1, 1'b0, 32'd31, 1'b0, 1'b0, "add_cin");
        send_one(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, "neg_overflow");
        send_one(32'h00000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, "sub_min_overflow");

        // Back-to-back stream with out_ready toggling every cycle.
        va = '{32'd25, 32'd650, 32'd7000, 32'd6758};
        vb = '{32'd49, 32'd1000, 32'd15000, 32'd2112};
        ve = '{32'd74, 32'd1650, 32'd22000, 32'd8870};
        n0 = got_q.size();
        i = 0;
        tog = 1'b0;
        cin = 1'b0; sub = 1'b0;
        for (int t = 0; t < 60 && got_q.size() < n0 + 4; t++) begin
            tog = ~tog;
            out_ready = tog;
            if (i < 4) begin
                in_valid = 1'b1; a = va[i]; b = vb[i];
                #1;
                if (in_ready) i++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_results(n0 + 4, "stream");
        for (int j = 0; j < 4; j++)
            if (got_q.size() > n0 + j)
                check("stream_literal", 64'(got_q[n0 + j].s), 64'(ve[j]));

        // Fill the pipeline, then stall for 10 cycles.
        repeat (2) tick();
        out_ready = 1'b0;
        k = 0;
        for (int t = 0; t < 20 && k < 4; t++) begin
            in_valid = 1'b1; a = 32'd100 + 32'(k); b = 32'd23; cin = 1'b0; sub = 1'b0;
            #1;
            if (in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        repeat (10) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_sum", 64'(sum), 64'd123);
            tick();
        end

        // Reset in the middle of the stall: outputs clear immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'd0);
        check("async_reset_sum", 64'(sum), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("in_ready_first_cycle", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        vcnt = 0;
        repeat (10) begin
            if (out_valid) vcnt++;
            tick();
        end
        check("no_stale_result", 64'(vcnt), 64'd0);

        // Mixed operands under random back-pressure and input gaps.
        k = 0;
        for (int t = 0; t < 2000 && k < 60; t++) begin
            out_ready = ($urandom_range(0, 9) < 6);
            in_valid = ($urandom_range(0, 3) != 0);
            a = $urandom(); b = $urandom();
            cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
            #1;
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3 * S) tick();
        check("random_all_accepted", 64'(k), 64'd60);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
